// File: rtl/sha3_pkg.sv
// Shared constants and state type for the SHA-3 unpadding stream block.
// Define SHA3_DOMAIN_SEP_EN to expect the SHA-3 domain-separation pad start (0x06).
package sha3_pkg;

  localparam int unsigned RATE_WORDS_DEF = 68;

`ifdef SHA3_DOMAIN_SEP_EN
  localparam logic [7:0] PAD_START = 8'h06;
`else
  localparam logic [7:0] PAD_START = 8'h01;
`endif

  localparam logic [7:0] PAD_END = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FLUSH,
    LAST
  } unpad_state_t;

endpackage

// File: rtl/sha3_pad_locate.sv
// Finds the last (highest-index, MSB-first) nonzero byte of a word and
// reports whether that byte is the pad-start marker.
module sha3_pad_locate
  import sha3_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] word,
  output logic [2:0]            idx,
  output logic                  found,
  output logic                  is_pad_start
);

  localparam int unsigned NB = DATA_WIDTH / 8;

  always_comb begin
    idx          = '0;
    found        = 1'b0;
    is_pad_start = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (word[DATA_WIDTH-1-8*i -: 8] != 8'h00) begin
        idx          = 3'(i);
        found        = 1'b1;
        is_pad_start = (word[DATA_WIDTH-1-8*i -: 8] == PAD_START);
      end
    end
  end

endmodule

// File: rtl/sha3_unpad.sv
// Strips SHA-3/Keccak pad10*1 padding from a word stream, holding one candidate
// word plus a zero-word run count. Pad start byte selected by SHA3_DOMAIN_SEP_EN.
module sha3_unpad
  import sha3_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RATE_WORDS = RATE_WORDS_DEF
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  S_TVALID,
  output logic                  S_TREADY,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  S_TLAST,
  output logic                  M_TVALID,
  input  logic                  M_TREADY,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  M_TLAST,
  output logic [2:0]            M_TUSER,
  output logic                  PAD_ERR
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned ZW = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam logic [ZW-1:0] ZMAX = ZW'(RATE_WORDS - 1);

  unpad_state_t state, nxt_state;

  logic [DATA_WIDTH-1:0] cand, nxt_cand;
  logic [DATA_WIDTH-1:0] latch, nxt_latch;
  logic [ZW-1:0]         zcnt, nxt_zcnt;
  logic                  to_last, nxt_to_last;
  logic [2:0]            last_user, nxt_last_user;
  logic                  pad_err, nxt_pad_err;

  logic                  out_valid, nxt_out_valid;
  logic [DATA_WIDTH-1:0] out_data, nxt_out_data;
  logic                  out_last, nxt_out_last;
  logic [2:0]            out_user, nxt_out_user;

  logic                  can_load, s_ready, accept;
  logic                  emit, emit_last;
  logic [DATA_WIDTH-1:0] emit_data;
  logic [2:0]            emit_user;

  logic [DATA_WIDTH-1:0] w_clr;
  logic [2:0]            w_idx, c_idx;
  logic                  w_found, c_found, w_is_start, c_is_start;

  // Final word with its pad-end bit removed; what remains decides where the pad start lives.
  assign w_clr = din & ~DATA_WIDTH'(PAD_END);

  sha3_pad_locate #(.DATA_WIDTH(DATA_WIDTH)) u_loc_w (
    .word         (w_clr),
    .idx          (w_idx),
    .found        (w_found),
    .is_pad_start (w_is_start)
  );

  sha3_pad_locate #(.DATA_WIDTH(DATA_WIDTH)) u_loc_c (
    .word         (cand),
    .idx          (c_idx),
    .found        (c_found),
    .is_pad_start (c_is_start)
  );

  function automatic logic [DATA_WIDTH-1:0] trim(input logic [DATA_WIDTH-1:0] w,
                                                 input logic [2:0]            k);
    trim = w;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i >= 32'(k)) trim[DATA_WIDTH-1-8*i -: 8] = 8'h00;
    end
  endfunction

  assign can_load = !out_valid || M_TREADY;
  assign s_ready  = ((state == IDLE) || (state == HOLD)) && can_load && !ARESET;
  assign accept   = S_TVALID && s_ready;

  always_comb begin
    nxt_state     = state;
    nxt_cand      = cand;
    nxt_latch     = latch;
    nxt_zcnt      = zcnt;
    nxt_to_last   = to_last;
    nxt_last_user = last_user;
    nxt_pad_err   = 1'b0;
    emit          = 1'b0;
    emit_data     = '0;
    emit_last     = 1'b0;
    emit_user     = '0;

    case (state)
      IDLE, HOLD: begin
        if (accept) begin
          if (S_TLAST) begin
            if (din[7] && w_found && w_is_start) begin
              nxt_latch     = trim(w_clr, w_idx);
              nxt_last_user = w_idx;
              nxt_to_last   = 1'b1;
              nxt_state     = (state == HOLD) ? FLUSH : LAST;
            end else if (din[7] && !w_found && c_found && c_is_start) begin
              // Pad started in the candidate: the held zero run is padding, drop it.
              nxt_latch     = trim(cand, c_idx);
              nxt_last_user = c_idx;
              nxt_zcnt      = '0;
              nxt_state     = LAST;
            end else begin
              nxt_pad_err = 1'b1;
              nxt_cand    = '0;
              nxt_zcnt    = '0;
              nxt_state   = IDLE;
            end
          end else if (state == IDLE) begin
            nxt_cand  = din;
            nxt_zcnt  = '0;
            nxt_state = HOLD;
          end else if (din == '0) begin
            // A run longer than one rate block cannot be padding; release the oldest word.
            if (zcnt == ZMAX) begin
              emit      = 1'b1;
              emit_data = cand;
              nxt_cand  = '0;
            end else begin
              nxt_zcnt = zcnt + ZW'(1);
            end
          end else if (zcnt == '0) begin
            emit      = 1'b1;
            emit_data = cand;
            nxt_cand  = din;
          end else begin
            nxt_latch   = din;
            nxt_to_last = 1'b0;
            nxt_state   = FLUSH;
          end
        end
      end

      FLUSH: begin
        if (can_load) begin
          emit      = 1'b1;
          emit_data = cand;
          if (zcnt != '0) begin
            nxt_cand = '0;
            nxt_zcnt = zcnt - ZW'(1);
          end else if (to_last) begin
            nxt_state = LAST;
          end else begin
            nxt_cand  = latch;
            nxt_state = HOLD;
          end
        end
      end

      LAST: begin
        if (can_load) begin
          emit      = 1'b1;
          emit_data = latch;
          emit_last = 1'b1;
          emit_user = last_user;
          nxt_cand  = '0;
          nxt_zcnt  = '0;
          nxt_state = IDLE;
        end
      end

      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    nxt_out_valid = out_valid;
    nxt_out_data  = out_data;
    nxt_out_last  = out_last;
    nxt_out_user  = out_user;
    if (emit) begin
      nxt_out_valid = 1'b1;
      nxt_out_data  = emit_data;
      nxt_out_last  = emit_last;
      nxt_out_user  = emit_user;
    end else if (M_TREADY) begin
      nxt_out_valid = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      cand      <= '0;
      latch     <= '0;
      zcnt      <= '0;
      to_last   <= 1'b0;
      last_user <= '0;
      pad_err   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_user  <= '0;
    end else begin
      state     <= nxt_state;
      cand      <= nxt_cand;
      latch     <= nxt_latch;
      zcnt      <= nxt_zcnt;
      to_last   <= nxt_to_last;
      last_user <= nxt_last_user;
      pad_err   <= nxt_pad_err;
      out_valid <= nxt_out_valid;
      out_data  <= nxt_out_data;
      out_last  <= nxt_out_last;
      out_user  <= nxt_out_user;
    end
  end

  assign S_TREADY = s_ready;
  assign M_TVALID = out_valid;
  assign dout     = out_data;
  assign M_TLAST  = out_last;
  assign M_TUSER  = out_user;
  assign PAD_ERR  = pad_err;

endmodule

// File: tb/tb_sha3_unpad.sv
// Directed bench for sha3_unpad (16-bit words, 4-word rate) with a byte-level
// unpadding model and a scoreboard; honours SHA3_DOMAIN_SEP_EN for the pad start.
module tb_sha3_unpad;

  localparam int DW   = 16;
  localparam int NB   = DW / 8;
  localparam int RATE = 4;
`ifdef SHA3_DOMAIN_SEP_EN
  localparam logic [7:0] PS    = 8'h06;
  localparam logic [7:0] OTHER = 8'h81;
`else
  localparam logic [7:0] PS    = 8'h01;
  localparam logic [7:0] OTHER = 8'h86;
`endif
  localparam logic [7:0] PC = PS | 8'h80;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [2:0]    user;
  } exp_t;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          S_TVALID, S_TREADY, S_TLAST;
  logic [DW-1:0] din;
  logic          M_TVALID, M_TREADY, M_TLAST;
  logic [DW-1:0] dout;
  logic [2:0]    M_TUSER;
  logic          PAD_ERR;

  int   checks = 0;
  int   errors = 0;
  int   err_pend = 0;
  bit   bp_on = 1'b0;
  bit   stall_req = 1'b0;
  exp_t exp_q[$];
  exp_t mdl_q[$];
  logic [DW-1:0] tx_w[$];

  always #5 ACLK = ~ACLK;

  sha3_unpad #(.DATA_WIDTH(DW), .RATE_WORDS(RATE)) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .S_TVALID (S_TVALID),
    .S_TREADY (S_TREADY),
    .din      (din),
    .S_TLAST  (S_TLAST),
    .M_TVALID (M_TVALID),
    .M_TREADY (M_TREADY),
    .dout     (dout),
    .M_TLAST  (M_TLAST),
    .M_TUSER  (M_TUSER),
    .PAD_ERR  (PAD_ERR)
  );

  // Sink ready: always high, held low on request, or random backpressure.
  initial begin
    M_TREADY = 1'b1;
    forever begin
      @(posedge ACLK);
      #1;
      if (bp_on) M_TREADY = 1'($urandom_range(0, 1));
      else       M_TREADY = !stall_req;
    end
  end

  // Unpad the whole padded message as a byte string; returns 1 on malformed padding.
  function automatic bit model_run();
    logic [7:0]    b[$];
    logic [DW-1:0] w;
    int            p, j, n, c, lst;
    mdl_q.delete();
    n = tx_w.size();
    foreach (tx_w[i])
      for (int k = 0; k < NB; k++) b.push_back(tx_w[i][DW-1-8*k -: 8]);
    lst = b.size() - 1;
    if ((b[lst] & 8'h80) == 8'h00) return 1'b1;
    b[lst] = b[lst] & 8'h7f;
    p = -1;
    foreach (b[k]) if (b[k] != 8'h00) p = k;
    if (p < 0) return 1'b1;
    if (b[p] != PS) return 1'b1;
    j = p / NB;
    c = n - 2 - j;
    if (j < n - 1 && c >= RATE) return 1'b1;
    for (int i = 0; i <= j; i++) begin
      w = '0;
      for (int k = 0; k < NB; k++)
        if (i < j || k < p % NB) w[DW-1-8*k -: 8] = b[i*NB+k];
      mdl_q.push_back('{data: w, last: (i == j), user: (i == j) ? 3'(p % NB) : 3'd0});
    end
    return 1'b0;
  endfunction

  // Scoreboard / protocol checks, sampled on the falling edge.
  initial begin
    exp_t          e;
    bit            prev_stall = 1'b0;
    bit            prev_err = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic          prev_l = 1'b0;
    logic [2:0]    prev_u = '0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        prev_stall = 1'b0;
        prev_err   = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!M_TVALID || dout !== prev_d || M_TLAST !== prev_l || M_TUSER !== prev_u) begin
            errors++;
            $display("FAIL hold_stable got v=%b d=%h l=%b u=%0d want v=1 d=%h l=%b u=%0d",
                     M_TVALID, dout, M_TLAST, M_TUSER, prev_d, prev_l, prev_u);
          end
        end
        if (M_TVALID && !M_TREADY) begin
          checks++;
          if (S_TREADY !== 1'b0) begin
            errors++;
            $display("FAIL sready_when_full got %b want 0", S_TREADY);
          end
        end
        if (M_TVALID && M_TREADY) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output got d=%h l=%b u=%0d want none", dout, M_TLAST, M_TUSER);
          end else begin
            e = exp_q.pop_front();
            if (dout !== e.data || M_TLAST !== e.last || (e.last && M_TUSER !== e.user)) begin
              errors++;
              $display("FAIL out_word got d=%h l=%b u=%0d want d=%h l=%b u=%0d",
                       dout, M_TLAST, M_TUSER, e.data, e.last, e.user);
            end
          end
        end
        if (PAD_ERR) begin
          checks++;
          if (err_pend == 0 || prev_err) begin
            errors++;
            $display("FAIL pad_err_pulse got 1 want 0 (pending=%0d prev=%b)", err_pend, prev_err);
          end else begin
            err_pend--;
          end
        end
        prev_err   = PAD_ERR;
        prev_stall = M_TVALID && !M_TREADY;
        prev_d     = dout;
        prev_l     = M_TLAST;
        prev_u     = M_TUSER;
      end
    end
  end

  task automatic chk(input string n, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", n, got, want);
    end
  endtask

  task automatic pin(input string n, input int idx, input logic [DW-1:0] d,
                     input logic l, input logic [2:0] u);
    checks++;
    if (idx >= mdl_q.size() || mdl_q[idx].data !== d || mdl_q[idx].last !== l ||
        mdl_q[idx].user !== u) begin
      errors++;
      $display("FAIL pin_%s[%0d] got size=%0d d=%h l=%b u=%0d want d=%h l=%b u=%0d", n, idx,
               mdl_q.size(), mdl_q[idx].data, mdl_q[idx].last, mdl_q[idx].user, d, l, u);
    end
  endtask

  task automatic send_msg(output int stalls);
    int t;
    stalls = 0;
    for (int i = 0; i < tx_w.size(); i++) begin
      S_TVALID = 1'b1;
      din      = tx_w[i];
      S_TLAST  = (i == tx_w.size() - 1);
      t = 0;
      @(negedge ACLK);
      while (!S_TREADY && t < 200) begin
        t++;
        stalls++;
        @(negedge ACLK);
      end
      if (!S_TREADY) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got S_TREADY=0 want 1 (word %0d)", i);
      end
      @(posedge ACLK);
      #1;
    end
    S_TVALID = 1'b0;
    S_TLAST  = 1'b0;
    din      = '0;
  endtask

  task automatic drain(input string n);
    int t = 0;
    while ((exp_q.size() != 0 || err_pend != 0) && t < 300) begin
      @(negedge ACLK);
      t++;
    end
    checks++;
    if (exp_q.size() != 0 || err_pend != 0) begin
      errors++;
      $display("FAIL drain_%s got words_left=%0d errs_left=%0d want 0 0", n, exp_q.size(), err_pend);
      exp_q.delete();
      err_pend = 0;
    end
    repeat (3) @(posedge ACLK);
    #1;
  endtask

  task automatic run_msg(input string n, input bit want_err, input bit want_tput,
                         input bit stall_mid);
    bit err;
    int st;
    err = model_run();
    checks++;
    if (err !== want_err) begin
      errors++;
      $display("FAIL model_err_%s got %b want %b", n, err, want_err);
    end
    if (err) err_pend++;
    else foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
    send_msg(st);
    if (want_tput) chk({"tput_", n}, DW'(st), '0);
    if (stall_mid) begin
      @(posedge ACLK);
      #1;
      stall_req = 1'b1;
      repeat (3) @(posedge ACLK);
      #1;
      stall_req = 1'b0;
    end
    drain(n);
  endtask

  task automatic check_reset_outputs(input string n);
    chk({n, "_mvalid"}, {15'd0, M_TVALID}, '0);
    chk({n, "_mlast"},  {15'd0, M_TLAST},  '0);
    chk({n, "_muser"},  {13'd0, M_TUSER},  '0);
    chk({n, "_dout"},   dout,              '0);
    chk({n, "_paderr"}, {15'd0, PAD_ERR},  '0);
    chk({n, "_sready"}, {15'd0, S_TREADY}, '0);
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL global_timeout got running want finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int st;
    ARESET   = 1'b1;
    S_TVALID = 1'b0;
    S_TLAST  = 1'b0;
    din      = '0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs("reset");
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;

    tx_w = '{16'hABCD, {8'hEF, PS}, 16'h0000, 16'h0080};
    void'(model_run());
    pin("m1", 0, 16'hABCD, 1'b0, 3'd0);
    pin("m1", 1, 16'hEF00, 1'b1, 3'd1);
    run_msg("pad_in_cand", 1'b0, 1'b0, 1'b0);

    tx_w = '{16'hABCD, {PS, 8'h00}, 16'h0000, 16'h0080};
    void'(model_run());
    pin("m2", 1, 16'h0000, 1'b1, 3'd0);
    run_msg("word_boundary", 1'b0, 1'b0, 1'b0);

    tx_w = '{16'h1234, 16'h0000, 16'h0000, {8'h56, PC}};
    void'(model_run());
    pin("m3", 2, 16'h0000, 1'b0, 3'd0);
    pin("m3", 3, 16'h5600, 1'b1, 3'd1);
    run_msg("flush_stall", 1'b0, 1'b0, 1'b1);

    tx_w = '{16'h1234};
    run_msg("err_no_end", 1'b1, 1'b0, 1'b0);
    tx_w = '{16'h0001};
    run_msg("err_0001", 1'b1, 1'b0, 1'b0);

    tx_w = '{{8'hAB, PC}};
    void'(model_run());
    pin("m6", 0, 16'hAB00, 1'b1, 3'd1);
    run_msg("combined_pad", 1'b0, 1'b0, 1'b0);
    tx_w = '{{8'hAB, OTHER}};
    run_msg("err_wrong_start", 1'b1, 1'b0, 1'b0);

    tx_w = '{{PS, 8'h80}};
    run_msg("empty_msg", 1'b0, 1'b0, 1'b0);

    tx_w = '{16'hABCD, {PS, 8'h00}, 16'h0000, 16'h0000, 16'h0000, 16'h0080};
    run_msg("max_zero_run", 1'b0, 1'b0, 1'b0);

    tx_w = '{16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, {8'h56, PC}};
    void'(model_run());
    pin("m9", 5, 16'h0000, 1'b0, 3'd0);
    pin("m9", 6, 16'h5600, 1'b1, 3'd1);
    bp_on = 1'b1;
    run_msg("long_zero_bp", 1'b0, 1'b0, 1'b0);
    bp_on = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;

    tx_w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, {8'h55, PC}};
    run_msg("throughput", 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a flush, then a clean message afterwards.
    tx_w = '{16'h1234, 16'h0000, 16'h0000, {8'h56, PC}};
    send_msg(st);
    @(posedge ACLK);
    #1;
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs("midreset");
    exp_q.delete();
    err_pend = 0;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    tx_w = '{16'hABCD, {8'hEF, PS}, 16'h0000, 16'h0080};
    run_msg("after_reset", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
